// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand loader: FSM states and opcodes.
// Optional build macro affecting this slice: ALU_LOADER_DEBOUNCE_EN.
package alu_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } state_e;

    localparam logic [3:0] OP_MAX = 4'd13;

    typedef enum logic [3:0] {
        SUB  = 4'd0,
        AND  = 4'd1,
        OR   = 4'd2,
        NOT  = 4'd3,
        XOR  = 4'd4,
        CPL1 = 4'd5,
        CPL2 = 4'd6,
        SAL  = 4'd7,
        SAR  = 4'd8,
        SLL  = 4'd9,
        SLR  = 4'd10,
        ROL  = 4'd11,
        ROR  = 4'd12,
        ADD  = 4'd13
    } op_e;

    function automatic logic op_in_range(input logic [3:0] code);
        return code <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Switch/button inputs and operand-set outputs of the ALU operand loader.
// Optional build macro affecting this slice: ALU_LOADER_DEBOUNCE_EN.
interface alu_operand_loader_if;
    logic [3:0] iData;
    logic       iLoad;
    logic       iClear;
    logic       iAck;
    logic [3:0] oA;
    logic [3:0] oB;
    logic [3:0] oOp;
    logic       oValid;
    logic       oOpErr;
    logic [1:0] oState;

    modport master (
        output iData, iLoad, iClear, iAck,
        input  oA, oB, oOp, oValid, oOpErr, oState
    );

    modport slave (
        input  iData, iLoad, iClear, iAck,
        output oA, oB, oOp, oValid, oOpErr, oState
    );
endinterface

// File: rtl/alu_btn_conditioner.sv
// Load button conditioning: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce filter is built only when ALU_LOADER_DEBOUNCE_EN is defined.
module alu_btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic       s1, s2, lvl, prev, armed;
    logic [1:0] flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          flt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flt <= 1'b0;
            cnt <= '0;
        end else if (s2 == flt) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            flt <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = flt;
`else
    assign lvl = s2;
`endif

    // Reset zeroes the synchronizer, so a button held through reset would look like
    // a fresh press; arm only once a genuine low has passed through the synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
            flush <= '0;
        end else begin
            prev  <= lvl;
            flush <= {flush[0], 1'b1};
            if (flush[1] && !s2) armed <= 1'b1;
        end
    end

    assign pulse = lvl & ~prev & armed;
endmodule

// File: rtl/alu_operand_loader.sv
// Sequential loader of ALU operands A, B and opcode from switches via a load button.
// Define ALU_LOADER_DEBOUNCE_EN to add the DEBOUNCE_CYCLES debounce filter on iLoad.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_loader_if.slave  bus
);
    logic       load_pulse;
    state_e     state_q, state_n;
    logic [3:0] a_q, a_n, b_q, b_n, op_q, op_n;
    logic       valid_q, valid_n, err_q, err_n;

    alu_btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.iLoad),
        .pulse (load_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            op_q    <= op_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        valid_n = valid_q;
        err_n   = err_q;
        if (bus.iClear) begin
            state_n = LOAD_A;
            valid_n = 1'b0;
            err_n   = 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: if (load_pulse) begin
                    a_n     = bus.iData;
                    state_n = LOAD_B;
                end
                LOAD_B: if (load_pulse) begin
                    b_n     = bus.iData;
                    state_n = LOAD_OP;
                end
                LOAD_OP: if (load_pulse) begin
                    if (op_in_range(bus.iData)) begin
                        op_n    = bus.iData;
                        err_n   = 1'b0;
                        valid_n = 1'b1;
                        state_n = READY;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                READY: if (bus.iAck) begin
                    valid_n = 1'b0;
                    state_n = LOAD_A;
                end
                default: state_n = LOAD_A;
            endcase
        end
    end

    assign bus.oA     = a_q;
    assign bus.oB     = b_q;
    assign bus.oOp    = op_q;
    assign bus.oValid = valid_q;
    assign bus.oOpErr = err_q;
    assign bus.oState = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader; honours ALU_LOADER_DEBOUNCE_EN for timing and glitch tests.
module tb_alu_operand_loader;
    import alu_pkg::*;

    localparam int unsigned DEB = 16;
`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int unsigned FILT = DEB;
`else
    localparam int unsigned FILT = 0;
`endif
    localparam int unsigned LAT = 3 + FILT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_loader_if bus();

    alu_operand_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] a, b, op;
        logic       valid, err;
        logic [1:0] st;
        string      name;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model: what the operator has entered so far
    int         m_state;
    logic [3:0] m_a, m_b, m_op;
    logic       m_valid, m_err;

    function automatic void m_reset();
        m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_err = 0;
    endfunction

    function automatic void m_load(input logic [3:0] d);
        case (m_state)
            0: begin m_a = d; m_state = 1; end
            1: begin m_b = d; m_state = 2; end
            2: if (int'(d) <= 13) begin
                   m_op = d; m_err = 0; m_valid = 1; m_state = 3;
               end else m_err = 1;
            default: ;
        endcase
    endfunction

    function automatic void m_ack();
        if (m_state == 3) begin m_valid = 0; m_state = 0; end
    endfunction

    function automatic void m_clear();
        m_state = 0; m_valid = 0; m_err = 0;
    endfunction

    function automatic void expect_now(input string name);
        exp_t e;
        e.a = m_a; e.b = m_b; e.op = m_op; e.valid = m_valid; e.err = m_err;
        e.st = 2'(m_state); e.name = name;
        q.push_back(e);
    endfunction

    // Monitor: pops expectations, and checks operand stability while valid is held
    logic       pv = 1'b0;
    logic [3:0] pa, pb, pop;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if ({bus.oA, bus.oB, bus.oOp, bus.oValid, bus.oOpErr, bus.oState} !==
                    {e.a, e.b, e.op, e.valid, e.err, e.st}) begin
                    fails++;
                    $display("FAIL %s: got a=%0d b=%0d op=%0d valid=%0b err=%0b st=%0d, expected a=%0d b=%0d op=%0d valid=%0b err=%0b st=%0d",
                             e.name, bus.oA, bus.oB, bus.oOp, bus.oValid, bus.oOpErr, bus.oState,
                             e.a, e.b, e.op, e.valid, e.err, e.st);
                end
            end
            if (rst_n && pv && bus.oValid === 1'b1) begin
                tests++;
                if ({bus.oA, bus.oB, bus.oOp} !== {pa, pb, pop}) begin
                    fails++;
                    $display("FAIL stable_while_valid: got a=%0d b=%0d op=%0d, expected a=%0d b=%0d op=%0d",
                             bus.oA, bus.oB, bus.oOp, pa, pb, pop);
                end
            end
            pv = rst_n && (bus.oValid === 1'b1);
            pa = bus.oA; pb = bus.oB; pop = bus.oOp;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check(input string name);
        @(posedge clk);
        #1;
        expect_now(name);
        wait_drain();
    endtask

    task automatic press(input logic [3:0] d, input int unsigned hold, input string name);
        int unsigned h;
        h = (hold < FILT + 2) ? FILT + 2 : hold;
        @(negedge clk);
        bus.iData = d;
        bus.iLoad = 1'b1;
        repeat (h) @(negedge clk);
        bus.iLoad = 1'b0;
        repeat (FILT + 4) @(negedge clk);
        m_load(d);
        check(name);
    endtask

    task automatic press_lat(input logic [3:0] d);
        @(negedge clk);
        bus.iData = d;
        bus.iLoad = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        expect_now("latency_before");
        @(posedge clk);
        #1;
        m_load(d);
        expect_now("latency_at");
        @(negedge clk);
        bus.iLoad = 1'b0;
        repeat (FILT + 4) @(negedge clk);
        wait_drain();
    endtask

    task automatic press_with_clear(input logic [3:0] d);
        @(negedge clk);
        bus.iData = d;
        bus.iLoad = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        bus.iClear = 1'b1;
        @(negedge clk);
        bus.iClear = 1'b0;
        bus.iLoad = 1'b0;
        repeat (FILT + 4) @(negedge clk);
        m_clear();
        check("clear_vs_load");
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.iAck = 1'b1;
        @(negedge clk);
        bus.iAck = 1'b0;
        m_ack();
        check("ack");
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.iClear = 1'b1;
        @(negedge clk);
        bus.iClear = 1'b0;
        m_clear();
        check("clear");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        bus.iData = '0; bus.iLoad = 1'b0; bus.iClear = 1'b0; bus.iAck = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        press_lat(4'd5);
        press(4'd3, 2, "load_b");
        press(4'd13, 1, "load_op_ready");
        press(4'd7, 3, "ignored_in_ready_1");
        press(4'd8, 3, "ignored_in_ready_2");
        do_ack();

        press(4'd9, 2, "a2");
        press(4'd2, 2, "b2");
        press(4'd14, 2, "op_err_14");
        press(4'd15, 2, "op_err_15");
        do_ack();
        press(4'd0, 2, "op_ok_0");
        do_ack();

        press(4'd1, 2, "a3");
        press_with_clear(4'd4);

        press(4'd6, 50, "held_50");
        press(4'd11, 2, "after_held");

        @(negedge clk);
        bus.iLoad = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FILT + 10) @(negedge clk);
        m_reset();
        check("held_through_reset");
        @(negedge clk);
        bus.iLoad = 1'b0;
        repeat (FILT + 4) @(negedge clk);
        press(4'd12, 2, "after_reset_press");

`ifdef ALU_LOADER_DEBOUNCE_EN
        @(negedge clk);
        bus.iData = 4'd3;
        bus.iLoad = 1'b1;
        repeat (10) @(negedge clk);
        bus.iLoad = 1'b0;
        repeat (FILT + 6) @(negedge clk);
        check("glitch_10");
        press(4'd3, 20, "press_20");
`endif

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      press(4'($urandom_range(0, 15)), $urandom_range(1, 6), "rand_press");
            else if (r == 6) do_ack();
            else if (r == 7) do_clear();
            else if (r == 8) press_with_clear(4'($urandom_range(0, 15)));
            else             press(4'($urandom_range(0, 15)), 30, "rand_long_press");
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required by the debounce filter; used only when ALU_LOADER_DEBOUNCE_EN is defined.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous active-low reset.
REQ-005 Port iData, input, 4: switch value captured as A, B or Op.
REQ-006 Port iLoad, input, 1: raw asynchronous load button.
REQ-007 Port iClear, input, 1: synchronous abort to LOAD_A.
REQ-008 Port iAck, input, 1: downstream ALU stage has consumed the operand set.
REQ-009 Port oA, output, 4: operand A to the arithmetic unit.
REQ-010 Port oB, output, 4: operand B to the arithmetic unit.
REQ-011 Port oOp, output, 4: opcode to the arithmetic unit, range 0..13.
REQ-012 Port oValid, output, 1: oA, oB and oOp form a complete, stable set.
REQ-013 Port oOpErr, output, 1: last opcode load was rejected as out of range.
REQ-014 Port oState, output, 2: current FSM state, for LED display.

Function
REQ-015 iLoad SHALL pass through a 2-flop synchronizer, then a rising-edge detector that produces a one-cycle load pulse.
REQ-016 Capture latency: registers SHALL update on the 3rd rising clk edge, counting the first edge that samples iLoad high as the 1st (without debounce).
REQ-017 A held iLoad SHALL produce exactly one load pulse; a new pulse needs iLoad low then high again.
REQ-018 FSM states and encodings SHALL be LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3, with oState equal to the encoding.
REQ-019 LOAD_A plus load pulse: oA <= iData; go to LOAD_B.
REQ-020 LOAD_B plus load pulse: oB <= iData; go to LOAD_OP.
REQ-021 LOAD_OP plus load pulse with iData <= 13: oOp <= iData, oOpErr <= 0, oValid <= 1; go to READY.
REQ-022 LOAD_OP plus load pulse with iData >= 14: oOp unchanged, oOpErr <= 1; stay in LOAD_OP.
REQ-023 In READY, oA, oB and oOp SHALL hold stable and oValid SHALL stay 1 until iAck is sampled high.
REQ-024 In READY, iAck=1 SHALL clear oValid on that edge and move to LOAD_A.
REQ-025 Load pulses in READY SHALL be ignored; iAck outside READY SHALL be ignored.
REQ-026 iClear=1 in any state SHALL force LOAD_A, oValid=0 and oOpErr=0 on that edge; oA, oB and oOp retain their values.
REQ-027 iClear SHALL take priority over a simultaneous load pulse or iAck.

Reset
REQ-028 While rst_n=0 at a clk edge: state LOAD_A; oA, oB, oOp, oValid, oOpErr = 0; synchronizer, edge and debounce registers = 0.
REQ-029 Reset mid-sequence SHALL discard partial loads; a button held through reset release SHALL NOT generate a pulse until it is released and pressed again.

Configuration
REQ-030 With ALU_LOADER_DEBOUNCE_EN defined, the synchronized iLoad SHALL change the filtered level only after DEBOUNCE_CYCLES consecutive equal samples, using a $clog2(DEBOUNCE_CYCLES+1)-bit counter; capture latency grows by DEBOUNCE_CYCLES.
REQ-031 Without ALU_LOADER_DEBOUNCE_EN, the synchronizer output SHALL feed the edge detector directly and no counter SHALL exist.

Structure
REQ-032 Shared package alu_pkg SHALL hold the FSM state enum, the OP_MAX=13 constant, and the opcode enum (SUB=0, AND=1, OR=2, NOT=3, XOR=4, CPL1=5, CPL2=6, SAL=7, SAR=8, SLL=9, SLR=10, ROL=11, ROR=12, ADD=13).
REQ-033 Synchronizer, debounce and edge detection SHALL be a sub-module named alu_btn_conditioner, with a one-cycle pulse output.

Verification
REQ-034 Without debounce, press-and-release iLoad with iData 5, then 3, then 13 -> oA=5, oB=3, oOp=13, oValid=1, oState=3.
REQ-035 In LOAD_OP, press with iData=14 -> oOpErr=1, oOp unchanged, state stays 2; then press with iData=0 -> oOpErr=0, oValid=1.
REQ-036 In READY, press iLoad twice, then assert iAck for one cycle -> values unchanged until iAck; oValid=0 and oState=0 the next cycle.
REQ-037 In LOAD_B, assert iClear in the same cycle as a load pulse -> oState=0, oB unchanged, oValid=0.
REQ-038 Hold iLoad high for 50 cycles -> exactly one capture. With the macro on and DEBOUNCE_CYCLES=16, a 10-cycle glitch -> no capture; a 20-cycle press -> one capture.
